input_arbiter_fifo: RTL
=======================

// Module: input_arbiter_fifo
// PURPOSE
//  N-channel successor to the two-source keyboard/UART input mux. Arbitrates NUM_CH
//  valid/ready byte sources into one output stream feeding the command handler.
//  Arbitration is fixed-priority or round-robin. Each accepted byte is tagged with its
//  source channel. A DEPTH-entry output FIFO absorbs command-handler stalls and
//  sustains one transfer per clock.
// PARAMETERS
//  DATA_W   8  width of each data word
//  NUM_CH   2  number of input channels (>=2); ch0 = keyboard, ch1 = UART
//  DEPTH    4  output FIFO entries (power of 2, >=2)
//  RR_MODE  0  0 = fixed priority (lowest index wins); 1 = round-robin
//  CH_W     $clog2(NUM_CH)  width of channel tag (localparam)
// PORTS
//  clk        in   1               single system clock (50 MHz)
//  reset      in   1               synchronous, active-high
//  in_data    in   NUM_CH*DATA_W   packed; channel i at [i*DATA_W +: DATA_W]
//  in_valid   in   NUM_CH          per-channel valid
//  in_ready   out  NUM_CH          per-channel ready (one-hot or zero)
//  out_data   out  DATA_W          FIFO head data
//  out_chan   out  CH_W            FIFO head source channel
//  out_valid  out  1               FIFO non-empty
//  out_ready  in   1               downstream accept
//  fifo_level out  $clog2(DEPTH)+1 entries currently held
//  overflow   out  1               sticky: a valid channel was refused for 256+ consecutive cycles
// BEHAVIOUR
//  Reset (sync, high): FIFO empty, all entries cleared, RR pointer = NUM_CH-1.
//   out_valid=0, out_data=0, out_chan=0, fifo_level=0, overflow=0.
//   Starvation counters are cleared. in_ready=0 while reset is high.
//  Grant (combinational from in_valid, count, RR pointer; never from out_ready):
//   - Grant is permitted only when fifo_level < DEPTH.
//   - Full FIFO: in_ready=0 even if out_ready=1 in the same cycle. No in->out comb path.
//   - Fixed mode: grant the lowest-index channel with valid=1.
//   - RR mode: search from (ptr+1) mod NUM_CH upward with wrap. The first valid channel wins.
//   - in_ready is one-hot on the granted channel and zero elsewhere. It stays zero when
//     no channel is valid.
//   - Transfer on channel i = in_valid[i] & in_ready[i].
//  RR pointer: loads the granted index on a transfer only; holds otherwise.
//  FIFO:
//   - push = any transfer. It writes {chan, data} at wr_ptr.
//   - pop = out_valid & out_ready.
//   - Pointers wrap mod DEPTH.
//   - Count update: push & pop -> unchanged; push only -> +1; pop only -> -1.
//   - Pop when empty is ignored. Push when full cannot occur (grant gated).
//  Latency: data accepted at edge N is visible on out_data/out_valid after edge N.
//   The output is registered, so there is one cycle of latency and no bypass.
//  Throughput: one push and one pop per cycle when neither full nor empty.
//  Output stability: while out_valid=1 and out_ready=0, out_data/out_chan hold.
//  Ordering: output order = acceptance order.
//  Starvation monitor:
//   - An 8-bit counter per channel increments while in_valid=1 and in_ready=0.
//   - It clears on that channel's transfer or when in_valid drops.
//   - At saturation (255) it holds and sets overflow. overflow clears only on reset.
//  Reset mid-operation: in-flight FIFO contents are discarded. No output transfer is
//   reported in the reset cycle.
//  Sources must hold data while valid and not ready. The block does not check this.
// TESTING
//  1 Reset then idle: all outputs 0, in_ready=0 for all channels, fifo_level=0.
//  2 RR_MODE=0, NUM_CH=2, out_ready=1: ch0=0x41 and ch1=0x55 valid together ->
//    0x41/chan0 first. Then 0x55/chan1 on the next cycle, once ch0 drops valid.
//  3 RR_MODE=1, NUM_CH=4, all valid, out_ready=1 -> grants cycle 0,1,2,3,0.
//    out_chan follows the same sequence one cycle later.
//  4 DEPTH=4, out_ready=0, ch0 streams 0x01..0x06 -> 4 accepted, fifo_level=4, in_ready=0.
//    Then out_ready=1 -> 0x01..0x04 in order, and 0x05 is accepted the cycle after the first pop.
//  5 RR_MODE=0, ch0 valid continuously, ch1 valid, out_ready=1 -> ch1 refused 256 cycles.
//    overflow=1 and it stays set after ch1 drops.
//  6 Assert reset with fifo_level=3 -> next cycle out_valid=0 and fifo_level=0.
//    No stale entry appears after reset release.

Source files
------------

// File: rtl/input_arbiter_fifo.sv
// input_arbiter_fifo: NUM_CH-way valid/ready byte arbiter (fixed or round-robin)
// feeding a DEPTH-entry channel-tagged output FIFO with a starvation monitor.
module input_arbiter_fifo #(
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 2,
    parameter int DEPTH   = 4,
    parameter int RR_MODE = 0,
    localparam int CH_W   = $clog2(NUM_CH),
    localparam int LW     = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_chan,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LW-1:0]            fifo_level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [CH_W-1:0]   r_chan [DEPTH];
    logic [AW-1:0]     r_wr, r_rd;
    logic [LW-1:0]     r_cnt;
    logic [CH_W-1:0]   r_ptr, w_gidx;
    logic [7:0]        r_starve [NUM_CH];
    logic              w_gnt_any, w_full, w_push, w_pop;

    // Scan from the lowest priority up so the last hit is the winner.
    always_comb begin
        w_gidx    = '0;
        w_gnt_any = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            int j;
            j = (RR_MODE != 0) ? (int'(r_ptr) + k) % NUM_CH : k - 1;
            if (in_valid[j]) begin
                w_gidx    = CH_W'(j);
                w_gnt_any = 1'b1;
            end
        end
    end

    assign w_full     = r_cnt == LW'(DEPTH);
    assign in_ready   = (!reset && !w_full && w_gnt_any) ? {{(NUM_CH-1){1'b0}}, 1'b1} << w_gidx : '0;
    assign w_push     = |(in_valid & in_ready);
    assign out_valid  = (r_cnt != '0) && !reset;
    assign w_pop      = out_valid && out_ready;
    assign out_data   = r_data[r_rd];
    assign out_chan   = r_chan[r_rd];
    assign fifo_level = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_chan[i] <= '0;
            end
            for (int i = 0; i < NUM_CH; i++) r_starve[i] <= '0;
            r_wr     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_ptr    <= CH_W'(NUM_CH - 1);
            overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_data[r_wr] <= in_data[w_gidx*DATA_W +: DATA_W];
                r_chan[r_wr] <= w_gidx;
                r_wr         <= r_wr + 1'b1;
                r_ptr        <= w_gidx;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + LW'(w_push) - LW'(w_pop);
            for (int i = 0; i < NUM_CH; i++) begin
                if (!in_valid[i] || in_ready[i]) r_starve[i] <= '0;
                else if (r_starve[i] == 8'hFF) overflow <= 1'b1;
                else r_starve[i] <= r_starve[i] + 8'd1;
            end
        end
    end
endmodule
